// File: rtl/maze_pkg.sv
// +----------------------------------------------------------------------+
// | maze_pkg: headings, walker states and heading-rotation helpers.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package maze_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MARK  = 3'd1,
    ST_PROBE = 3'd2,
    ST_EVAL  = 3'd3,
    ST_DONE  = 3'd4,
    ST_FAIL  = 3'd5
  } state_e;

  function automatic dir_e rot_cw(input dir_e d);
    return dir_e'(d + 2'd1);
  endfunction

  function automatic dir_e rot_ccw(input dir_e d);
    return dir_e'(d - 2'd1);
  endfunction

  function automatic dir_e rot_180(input dir_e d);
    return dir_e'(d + 2'd2);
  endfunction

  // Wall-follower preference order: hand side first, then ahead, then the
  // other side, finally turn back.
  function automatic dir_e cand_dir(input dir_e d, input logic hand, input logic [1:0] t);
    dir_e r;
    case (t)
      2'd0:    r = hand ? rot_ccw(d) : rot_cw(d);
      2'd1:    r = d;
      2'd2:    r = hand ? rot_cw(d) : rot_ccw(d);
      default: r = rot_180(d);
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/maze_nbr.sv
// +----------------------------------------------------------------------+
// | maze_nbr: combinational neighbour cell and in-range flag.            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module maze_nbr
  import maze_pkg::*;
#(
  parameter int ROWS = 64,
  parameter int COLS = 64,
  parameter int W    = 6
) (
  input  logic [W-1:0] row_i,
  input  logic [W-1:0] col_i,
  input  dir_e         dir_i,
  output logic [W-1:0] row_o,
  output logic [W-1:0] col_o,
  output logic         valid_o
);

  localparam logic [W-1:0] ROW_LAST = W'(ROWS - 1);
  localparam logic [W-1:0] COL_LAST = W'(COLS - 1);

  always_comb begin
    row_o   = row_i;
    col_o   = col_i;
    valid_o = 1'b0;
    case (dir_i)
      DIR_UP: begin
        valid_o = (row_i != '0);
        row_o   = row_i - W'(1);
      end
      DIR_RIGHT: begin
        valid_o = (col_i < COL_LAST);
        col_o   = col_i + W'(1);
      end
      DIR_DOWN: begin
        valid_o = (row_i < ROW_LAST);
        row_o   = row_i + W'(1);
      end
      default: begin
        valid_o = (col_i != '0);
        col_o   = col_i - W'(1);
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/maze_follower.sv
// +----------------------------------------------------------------------+
// | maze_follower: wall-following maze walker with path marking.         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module maze_follower
  import maze_pkg::*;
#(
  parameter int ROWS      = 64,
  parameter int COLS      = 64,
  parameter int W         = 6,
  parameter int MAX_STEPS = 4096,
  parameter int SW        = 13
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [W-1:0]  starting_row,
  input  logic [W-1:0]  starting_col,
  input  logic [1:0]    start_dir,
  input  logic          hand,
  input  logic          maze_in,
  output logic [W-1:0]  row,
  output logic [W-1:0]  col,
  output logic          maze_oe,
  output logic          maze_we,
  output logic          done,
  output logic          fail,
  output logic          busy,
  output logic [SW-1:0] steps
);

  localparam logic [W-1:0]  ROW_LAST  = W'(ROWS - 1);
  localparam logic [W-1:0]  COL_LAST  = W'(COLS - 1);
  localparam logic [SW-1:0] STEPS_MAX = SW'(MAX_STEPS);

  state_e        state_q, state_d;
  logic [W-1:0]  cur_row_q, cur_row_d;
  logic [W-1:0]  cur_col_q, cur_col_d;
  dir_e          dir_q, dir_d;
  logic [1:0]    try_q, try_d;
  logic          hand_q, hand_d;
  logic [SW-1:0] steps_q, steps_d;

  dir_e          cand;
  logic [W-1:0]  nb_row, nb_col;
  logic          nb_valid;
  logic          on_border;

  assign cand = cand_dir(dir_q, hand_q, try_q);

  maze_nbr #(
    .ROWS (ROWS),
    .COLS (COLS),
    .W    (W)
  ) u_nbr (
    .row_i   (cur_row_q),
    .col_i   (cur_col_q),
    .dir_i   (cand),
    .row_o   (nb_row),
    .col_o   (nb_col),
    .valid_o (nb_valid)
  );

  assign on_border = (cur_row_q == '0) || (cur_row_q == ROW_LAST) ||
                     (cur_col_q == '0) || (cur_col_q == COL_LAST);

  always_comb begin
    state_d   = state_q;
    cur_row_d = cur_row_q;
    cur_col_d = cur_col_q;
    dir_d     = dir_q;
    try_d     = try_q;
    hand_d    = hand_q;
    steps_d   = steps_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (start) begin
          cur_row_d = starting_row;
          cur_col_d = starting_col;
          dir_d     = dir_e'(start_dir);
          hand_d    = hand;
          steps_d   = '0;
          try_d     = 2'd0;
          state_d   = ST_MARK;
        end
      end
      ST_MARK: begin
        try_d = 2'd0;
        if ((steps_q != '0) && on_border) begin
          state_d = ST_DONE;
        end else if (steps_q == STEPS_MAX) begin
          state_d = ST_FAIL;
        end else begin
          state_d = ST_PROBE;
        end
      end
      ST_PROBE: begin
        // An off-grid neighbour is a wall without spending a read cycle.
        if (nb_valid) begin
          state_d = ST_EVAL;
        end else if (try_q == 2'd3) begin
          state_d = ST_FAIL;
        end else begin
          try_d   = try_q + 2'd1;
          state_d = ST_PROBE;
        end
      end
      ST_EVAL: begin
        if (maze_in) begin
          if (try_q == 2'd3) begin
            state_d = ST_FAIL;
          end else begin
            try_d   = try_q + 2'd1;
            state_d = ST_PROBE;
          end
        end else begin
          cur_row_d = nb_row;
          cur_col_d = nb_col;
          dir_d     = cand;
          steps_d   = (steps_q == STEPS_MAX) ? steps_q : steps_q + SW'(1);
          state_d   = ST_MARK;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cur_row_q <= '0;
      cur_col_q <= '0;
      dir_q     <= DIR_UP;
      try_q     <= 2'd0;
      hand_q    <= 1'b0;
      steps_q   <= '0;
    end else begin
      state_q   <= state_d;
      cur_row_q <= cur_row_d;
      cur_col_q <= cur_col_d;
      dir_q     <= dir_d;
      try_q     <= try_d;
      hand_q    <= hand_d;
      steps_q   <= steps_d;
    end
  end

  always_comb begin
    maze_we = (state_q == ST_MARK);
    maze_oe = (state_q == ST_PROBE) && nb_valid;
    busy    = (state_q == ST_MARK) || (state_q == ST_PROBE) || (state_q == ST_EVAL);
    done    = (state_q == ST_DONE);
    fail    = (state_q == ST_FAIL);
    steps   = steps_q;
    row     = cur_row_q;
    col     = cur_col_q;
    if (maze_oe || (state_q == ST_EVAL)) begin
      row = nb_row;
      col = nb_col;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_maze_follower.sv
// +----------------------------------------------------------------------+
// | tb_maze_follower: directed table-driven bench on an 8x8 maze.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_maze_follower;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] starting_row;
  logic [2:0] starting_col;
  logic [1:0] start_dir;
  logic       hand;
  logic       maze_in;
  logic [2:0] row;
  logic [2:0] col;
  logic       maze_oe;
  logic       maze_we;
  logic       done;
  logic       fail;
  logic       busy;
  logic [4:0] steps;

  maze_follower #(
    .ROWS      (8),
    .COLS      (8),
    .W         (3),
    .MAX_STEPS (16),
    .SW        (5)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .starting_row (starting_row),
    .starting_col (starting_col),
    .start_dir    (start_dir),
    .hand         (hand),
    .maze_in      (maze_in),
    .row          (row),
    .col          (col),
    .maze_oe      (maze_oe),
    .maze_we      (maze_we),
    .done         (done),
    .fail         (fail),
    .busy         (busy),
    .steps        (steps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous maze RAM: data for the PROBE address appears during EVAL.
  logic mem [8][8];
  always @(posedge clk) begin
    if (!rst_n)       maze_in <= 1'b1;
    else if (maze_oe) maze_in <= mem[row][col];
    else              maze_in <= 1'b1;
  end

  int we_cnt = 0;
  int oe_cnt = 0;
  int viol   = 0;
  always @(negedge clk) begin
    if (maze_we) we_cnt++;
    if (maze_oe) oe_cnt++;
    if (maze_oe && maze_we) viol++;
    if (done && fail) viol++;
    if (done && (steps == 5'd0)) viol++;
    if (busy && (done || fail)) viol++;
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  task automatic load_maze(input int id);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        mem[r][c] = 1'b1;
    case (id)
      0: for (int c = 0; c < 8; c++) mem[3][c] = 1'b0;
      1: ;
      2: begin
        for (int r = 0; r < 8; r++) mem[r][4] = 1'b0;
        mem[4][3] = 1'b0;
      end
      3: begin
        mem[3][3] = 1'b0; mem[3][4] = 1'b0;
        mem[4][3] = 1'b0; mem[4][4] = 1'b0;
      end
      default: begin
        mem[0][2] = 1'b0; mem[1][2] = 1'b0; mem[2][2] = 1'b0;
        mem[2][1] = 1'b0; mem[2][0] = 1'b0;
      end
    endcase
  endtask

  task automatic launch(input logic [2:0] r, input logic [2:0] c,
                        input logic [1:0] d, input logic h);
    @(negedge clk);
    starting_row = r;
    starting_col = c;
    start_dir    = d;
    hand         = h;
    start        = 1'b1;
    @(negedge clk);
    start        = 1'b0;
  endtask

  task automatic wait_end(input string name);
    bit to;
    to = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (done || fail) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
    end
    check({name, " timeout"}, int'(to), 0);
  endtask

  typedef struct {
    logic [2:0] r;
    logic [2:0] c;
    logic [1:0] d;
    logic       h;
    int         maze;
    int         e_done;
    int         e_fail;
    int         e_steps;
    int         e_row;
    int         e_col;
    int         e_we;
    int         e_oe;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int we0, oe0;
    string nm;

    vecs[0] = '{3'd3, 3'd0, 2'd1, 1'b0, 0, 1, 0, 7,  3, 7, 8,  14};
    vecs[1] = '{3'd4, 3'd4, 2'd0, 1'b0, 1, 0, 1, 0,  4, 4, 1,  4};
    vecs[2] = '{3'd4, 3'd4, 2'd1, 1'b0, 2, 1, 0, 3,  7, 4, 4,  5};
    vecs[3] = '{3'd4, 3'd4, 2'd1, 1'b1, 2, 1, 0, 4,  0, 4, 5,  7};
    vecs[4] = '{3'd3, 3'd3, 2'd0, 1'b0, 3, 0, 1, 16, 3, 3, 17, 16};
    vecs[5] = '{3'd0, 3'd2, 2'd0, 1'b0, 4, 1, 0, 4,  2, 0, 5,  8};

    rst_n = 1'b0;
    start = 1'b1;
    starting_row = 3'd5;
    starting_col = 3'd5;
    start_dir = 2'd2;
    hand = 1'b0;
    load_maze(0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);

    check("reset busy",  int'(busy), 0);
    check("reset done",  int'(done), 0);
    check("reset fail",  int'(fail), 0);
    check("reset steps", int'(steps), 0);
    check("reset row",   int'(row), 0);
    check("reset col",   int'(col), 0);
    check("reset oe",    int'(maze_oe), 0);
    check("reset we",    int'(maze_we), 0);

    for (int i = 0; i < 6; i++) begin
      load_maze(vecs[i].maze);
      we0 = we_cnt;
      oe0 = oe_cnt;
      launch(vecs[i].r, vecs[i].c, vecs[i].d, vecs[i].h);
      nm = $sformatf("v%0d", i);
      check({nm, " busy"}, int'(busy), 1);
      wait_end(nm);
      check({nm, " done"},  int'(done), vecs[i].e_done);
      check({nm, " fail"},  int'(fail), vecs[i].e_fail);
      check({nm, " steps"}, int'(steps), vecs[i].e_steps);
      check({nm, " row"},   int'(row), vecs[i].e_row);
      check({nm, " col"},   int'(col), vecs[i].e_col);
      check({nm, " we"},    we_cnt - we0, vecs[i].e_we);
      check({nm, " oe"},    oe_cnt - oe0, vecs[i].e_oe);
    end

    // Sticky result, then a new start clears it.
    repeat (4) @(negedge clk);
    check("sticky done", int'(done), 1);
    check("sticky oe",   int'(maze_oe), 0);
    load_maze(0);
    launch(3'd3, 3'd0, 2'd1, 1'b0);
    check("restart done clr", int'(done), 0);
    check("restart busy",     int'(busy), 1);

    // Reset asserted while the walker is in EVAL on step 3.
    begin
      bit found;
      found = 1'b0;
      for (int i = 0; i < 500; i++) begin
        if ((steps == 5'd3) && maze_oe) begin
          found = 1'b1;
          break;
        end
        @(negedge clk);
      end
      check("reach step3 probe", int'(found), 1);
    end
    @(negedge clk);
    check("eval busy", int'(busy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst busy",  int'(busy), 0);
    check("midrst done",  int'(done), 0);
    check("midrst fail",  int'(fail), 0);
    check("midrst steps", int'(steps), 0);
    check("midrst row",   int'(row), 0);
    check("midrst col",   int'(col), 0);
    check("midrst oe",    int'(maze_oe), 0);
    check("midrst we",    int'(maze_we), 0);

    // Fresh walk; a start pulse while busy must be ignored.
    launch(3'd3, 3'd0, 2'd1, 1'b0);
    repeat (3) @(negedge clk);
    starting_row = 3'd0;
    starting_col = 3'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_end("fresh");
    check("fresh done",  int'(done), 1);
    check("fresh steps", int'(steps), 7);
    check("fresh row",   int'(row), 3);
    check("fresh col",   int'(col), 7);

    check("protocol violations", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
